// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, in-order credit-limited imem requests and an instruction FIFO to decode.
// Define IF_MISALIGN_TRAP_EN to add a sticky fetch_misaligned flag for unaligned redirect targets.
module if_stage #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            nreset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic            fetch_misaligned
`endif
);
   localparam int              PW   = $clog2(FIFO_DEPTH);
   localparam int              CW   = PW + 1;
   localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'b100};

   logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d, cnt_q, cnt_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0]     data_q [FIFO_DEPTH];
   logic [XLEN-1:0] epc_q  [FIFO_DEPTH];
   logic            mis_q, mis_d;
   logic [CW:0]     credit_s;
   logic [XLEN-1:0] target_s;
   logic            req_valid_s, req_fire_s, head_valid_s, push_s, pop_s;

   // Credit check, handshake qualifiers and next state for PC, counters and FIFO pointers
   always_comb begin
      credit_s     = {1'b0, out_cnt_q} + {1'b0, cnt_q};
      target_s     = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
      // outstanding already counts responses that will be dropped, so credit stays conservative
      req_valid_s  = nreset && (credit_s < (CW+1)'(FIFO_DEPTH)) && !redirect_valid && !mis_q;
      req_fire_s   = req_valid_s && imem_req_ready;
      head_valid_s = (cnt_q != {CW{1'b0}});
      pop_s        = head_valid_s && inst_ready && !redirect_valid;
      push_s       = imem_rsp_valid && !redirect_valid && (drop_cnt_q == {CW{1'b0}});

      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_cnt_d = drop_cnt_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mis_d      = mis_q;
      out_cnt_d  = out_cnt_q + CW'(req_fire_s) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
         pc_d       = target_s;
         rsp_pc_d   = target_s;
         cnt_d      = {CW{1'b0}};
         wr_ptr_d   = {PW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         drop_cnt_d = out_cnt_q - CW'(imem_rsp_valid);
`ifdef IF_MISALIGN_TRAP_EN
         mis_d      = (redirect_pc[1:0] != 2'b00);
`else
         mis_d      = 1'b0;
`endif
      end else begin
         if (req_fire_s) begin
            pc_d = pc_q + FOUR;
         end else begin
            pc_d = pc_q;
         end
         if (imem_rsp_valid && (drop_cnt_q != {CW{1'b0}})) begin
            drop_cnt_d = drop_cnt_q - CW'(1'b1);
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
         if (push_s) begin
            rsp_pc_d = rsp_pc_q + FOUR;
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
         end else begin
            rsp_pc_d = rsp_pc_q;
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // State registers and FIFO storage
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pc_q       <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_cnt_q  <= {CW{1'b0}};
         drop_cnt_q <= {CW{1'b0}};
         cnt_q      <= {CW{1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         mis_q      <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i] <= 32'h0000_0000;
            epc_q[i]  <= {XLEN{1'b0}};
         end
      end else begin
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mis_q      <= mis_d;
         if (push_s) begin
            data_q[wr_ptr_q] <= imem_rsp_data;
            epc_q[wr_ptr_q]  <= rsp_pc_q;
         end
      end
   end

   // Head presentation to decode; fields read as zero whenever the FIFO is empty
   always_comb begin
      if (head_valid_s) begin
         inst    = data_q[rd_ptr_q];
         inst_pc = epc_q[rd_ptr_q];
      end else begin
         inst    = 32'h0000_0000;
         inst_pc = {XLEN{1'b0}};
      end
      inst_valid     = head_valid_s;
      opcode         = inst[6:0];
      funct3         = inst[14:12];
      funct7         = inst[31:25];
      imem_req_valid = req_valid_s;
      imem_req_addr  = pc_q;
   end

`ifdef IF_MISALIGN_TRAP_EN
   assign fetch_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a memory model with per-request epochs feeds an expected
// instruction queue; a separate monitor compares the decode-side head and the request channel each cycle.
module tb_if_stage;
   localparam int          XLEN  = 32;
   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
`ifdef IF_MISALIGN_TRAP_EN
   logic        fetch_misaligned;
`endif

   if_stage #(.XLEN(XLEN), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .nreset(nreset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .opcode(opcode), .funct3(funct3), .funct7(funct7)
`ifdef IF_MISALIGN_TRAP_EN
      , .fetch_misaligned(fetch_misaligned)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int ep; int due; } req_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

   req_t        pending[$];   // accepted requests not yet answered, including doomed ones
   ent_t        exp_q[$];     // instructions decode should see, in order
   logic [31:0] fetch_pc;
   bit          mis;
   bit          run;
   int          epoch, cyc;
   int          n_cmp, n_err;
   int          p_rdy, p_irdy, p_redir, lat_min, lat_max;

   // cycles, req_ready %, inst_ready %, redirect %, min latency, max latency
   int ph [8][6] = '{
      '{ 20, 100, 100,  0, 1, 1},
      '{ 30, 100,   0,  0, 1, 1},
      '{ 30, 100, 100,  0, 1, 1},
      '{ 20,   0, 100,  0, 1, 1},
      '{300,  70,  70,  5, 1, 4},
      '{300,  90,  50, 15, 3, 3},
      '{300,  50,  50, 30, 1, 6},
      '{200,  80,  80, 10, 1, 3}
   };

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h0000_0033;
      return (a * 32'h9E37_79B9) ^ 32'h5A3C_0F17;
   endfunction

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      t = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
      return t;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr", imem_req_addr, RPC);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_opcode", opcode, 0);
      check("rst_funct3", funct3, 0);
      check("rst_funct7", funct7, 0);
`ifdef IF_MISALIGN_TRAP_EN
      check("rst_misaligned", fetch_misaligned, 0);
`endif
   endtask

   task automatic quiet_inputs();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;  inst_ready = 1'b0;
   endtask

   task automatic model_clear();
      pending.delete(); exp_q.delete();
      fetch_pc = RPC; mis = 1'b0; epoch++;
   endtask

   // One cycle: drive at posedge+1, then advance the model just after the monitor has sampled.
   task automatic drive_cycle();
      req_t r;
      @(posedge clk); #1;
      cyc++;
      imem_req_ready = ($urandom_range(0, 99) < p_rdy);
      inst_ready     = ($urandom_range(0, 99) < p_irdy);
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      redirect_pc    = pick_target();
      if (pending.size() > 0 && pending[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pending[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk); #1;
      if (redirect_valid) begin
         epoch++;
         exp_q.delete();
         fetch_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IF_MISALIGN_TRAP_EN
         mis = (redirect_pc[1:0] != 2'b00);
`endif
      end
      if (imem_rsp_valid) begin
         r = pending.pop_front();
         if (r.ep == epoch) begin
            check("fifo_room", exp_q.size() < DEPTH, 1);
            exp_q.push_back('{mem_word(r.addr), r.addr});
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         pending.push_back('{fetch_pc, epoch, cyc + $urandom_range(lat_min, lat_max)});
         fetch_pc += 32'd4;
      end
   endtask

   task automatic mid_reset();
      @(posedge clk); #1;
      nreset = 1'b0;
      quiet_inputs();
      #1;
      check_reset_outputs();
      model_clear();
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
   endtask

   // Monitor: request channel and decode head against the model every cycle
   initial begin : monitor
      ent_t e;
      bit   exp_rv;
      forever begin
         @(negedge clk);
         if (run && nreset) begin
            exp_rv = ((pending.size() + exp_q.size()) < DEPTH) && !redirect_valid && !mis;
            check("req_valid", imem_req_valid, exp_rv);
            check("req_addr", imem_req_addr, fetch_pc);
            check("inst_valid", inst_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               check("inst", inst, e.data);
               check("inst_pc", inst_pc, e.pc);
               check("opcode", opcode, e.data[6:0]);
               check("funct3", funct3, e.data[14:12]);
               check("funct7", funct7, e.data[31:25]);
               if (inst_ready && !redirect_valid) void'(exp_q.pop_front());
            end else begin
               check("inst_empty", inst, 0);
               check("inst_pc_empty", inst_pc, 0);
               check("opcode_empty", opcode, 0);
            end
`ifdef IF_MISALIGN_TRAP_EN
            check("misaligned", fetch_misaligned, mis);
`endif
         end
      end
   end

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; epoch = 0; run = 1'b0;
      quiet_inputs();
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      nreset = 1'b1;
      run = 1'b1;
      for (int p = 0; p < 7; p++) begin
         p_rdy = ph[p][1]; p_irdy = ph[p][2]; p_redir = ph[p][3];
         lat_min = ph[p][4]; lat_max = ph[p][5];
         repeat (ph[p][0]) drive_cycle();
      end
      mid_reset();
      p_rdy = ph[7][1]; p_irdy = ph[7][2]; p_redir = ph[7][3];
      lat_min = ph[7][4]; lat_max = ph[7][5];
      repeat (ph[7][0]) drive_cycle();
      @(negedge clk); #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the decode/controller logic.
- Keeps the PC and issues in-order requests to instruction memory over a valid/ready channel.
- Buffers returned instructions in a small FIFO and presents the head instruction to decode, with opcode/funct3/funct7 pre-sliced for the controller.
- Supports redirects (branch/jump): flushes the FIFO and discards in-flight responses.

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nreset  input  1  reset, asynchronous, active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address (current PC).
- imem_rsp_valid  input  1  response valid; always accepted, in request order, latency >= 1 cycle.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  single-cycle redirect strobe.
- redirect_pc  input  XLEN  redirect target.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  decode consumes head.
- inst  output  32  head instruction.
- inst_pc  output  XLEN  PC of head instruction.
- opcode  output  7  inst[6:0].
- funct3  output  3  inst[14:12].
- funct7  output  7  inst[31:25].

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc = rsp_pc = RESET_PC; outstanding = drop_cnt = fifo count = 0.
  - imem_req_valid = 0, inst_valid = 0; inst, inst_pc, opcode, funct3, funct7 all 0.
- Request credit rule:
  - imem_req_valid = 1 iff (outstanding + fifo_count) < FIFO_DEPTH and redirect_valid = 0.
  - outstanding includes responses that will be dropped.
  - imem_req_addr = pc at all times.
  - While imem_req_valid = 1 and imem_req_ready = 0, addr and valid stay stable.
- Request accept (valid & ready): pc += 4 (mod 2^XLEN wrap); outstanding += 1.
- Response handling (imem_rsp_valid):
  - outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1; data discarded.
  - Otherwise: push {data, rsp_pc} into FIFO; rsp_pc += 4.
- Latency: a response arriving in cycle N drives inst_valid in cycle N+1 if the FIFO was empty. No combinational path from imem_rsp_* to inst_*.
- Pop: inst_valid & inst_ready removes the head.
- Push and pop in the same cycle: both take effect; count unchanged. Push into a full FIFO cannot occur by the credit rule; the bench asserts this.
- Output fields: opcode, funct3, funct7, inst and inst_pc reflect the FIFO head when inst_valid = 1, and are 0 when the FIFO is empty.
- Redirect (redirect_valid = 1 in cycle N):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; rsp_pc gets the same value.
  - FIFO flushed; any pop in cycle N is ignored.
  - A response arriving in cycle N is discarded.
  - drop_cnt <= outstanding - imem_rsp_valid (counts every still-pending response).
  - No request issued in cycle N; normal fetch from the new PC starts in cycle N+1.
- Back-to-back redirects: the latest target wins; drop_cnt is recomputed each time.
- Reset mid-operation: all state cleared immediately. The memory side is reset on the same nreset, so no stale responses arrive afterwards.
- Counters outstanding and drop_cnt are sized to hold the value FIFO_DEPTH.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 sets fetch_misaligned (sticky), flushes as normal, and holds imem_req_valid = 0.
  - Cleared by the next aligned redirect or by reset.
- Undefined: no extra port; low two bits of redirect_pc are silently cleared.

Test Plan:
1. Reset, req_ready = 1, 1-cycle memory returning 32'h0000_0033 at 0x0 -> inst_valid = 1, inst_pc = 0x0, opcode = 7'b0110011, funct3 = 0, funct7 = 0; next imem_req_addr = 0x4.
2. inst_ready = 0, memory returns 0x11, 0x22, 0x33 at 0x0, 0x4, 0x8 -> imem_req_valid drops after two accepts, FIFO holds 0x11 then 0x22. Raising inst_ready pops them in order, and fetch resumes at 0x8.
3. imem_req_ready = 0 for 5 cycles -> imem_req_addr held at 0x4, imem_req_valid stays 1, pc not incremented.
4. Two requests outstanding (3-cycle memory), redirect to 0x100 -> both responses discarded, first inst_pc = 0x100.
5. Redirect coinciding with a response and a pop -> response dropped, FIFO empty next cycle, drop_cnt = outstanding - 1.
6. nreset low mid-stream -> all outputs 0 immediately; after release imem_req_addr = RESET_PC. With IF_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_misaligned = 1 and no requests until a redirect to 0x200.
